ram_moc_unit: RTL and testbench
===============================

# ram_moc_unit

Byte-addressable, big-endian data/instruction memory with a multi-cycle Memory-Operation-Complete (MOC) handshake. Sits directly downstream of the multicycle CPU datapath. Consumes the MAR address, MDR write data, rw/byte strobes and memory enable from the control unit. Returns read data to IR/MDR and signals completion on `moc` so the control FSM can leave its wait state.

## Interface
Parameters:
- `DEPTH`, 512: memory size in bytes; power of two, minimum 4.
- `LATENCY`, 2: wait cycles between request capture and access; range 0–15.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_enable`  in  1  request strobe; held high by the requester until `moc` is seen.
- `rw`  in  1  1 = read, 0 = write.
- `byte`  in  1  1 = byte access, 0 = word access.
- `address`  in  32  byte address.
- `data_in`  in  32  write data; the byte write uses `[7:0]`.
- `data_out`  out  32  read data, held until the next read completes.
- `moc`  out  1  operation complete.
- `align_err`  out  1  misaligned word access flag (see Configuration).

## Operation
- FSM states are IDLE, WAIT, DONE.
- IDLE:
  - On `mem_enable`=1, register `address`, `data_in`, `rw` and `byte`.
  - Load the wait counter with `LATENCY`.
  - Go to WAIT, or straight to DONE's access step if `LATENCY`=0.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, perform the access and go to DONE.
  - Inputs changing during WAIT are ignored; the captured values are used.
- Access:
  - Effective byte index is `address mod DEPTH`; addresses wrap, with no fault.
  - Word read: `data_out = {m[a], m[a+1], m[a+2], m[a+3]}`, where `a` is the index with bits [1:0] cleared. Big-endian.
  - Byte read: `data_out = {24'd0, m[idx]}`, zero-extended. Sign extension belongs to the datapath.
  - Word write: `m[a..a+3] = data_in[31:24], [23:16], [15:8], [7:0]`.
  - Byte write: `m[idx] = data_in[7:0]`.
  - A write leaves `data_out` unchanged.
- DONE:
  - `moc`=1 while `mem_enable` stays high.
  - When `mem_enable`=0, `moc` drops, go to IDLE.
  - A new request is accepted only from IDLE.
- Dropping `mem_enable` during WAIT aborts the request: go to IDLE, no memory update, `moc` never asserted.
- Reset (asynchronous, any state):
  - State = IDLE, `moc`=0, `data_out`=0, `align_err`=0, counter=0.
  - Memory array contents are not cleared.

## Timing
- Request sampled in cycle N; access occurs at edge N+1+`LATENCY`.
- `moc` and `data_out` are valid from that same edge. Minimum request-to-`moc` latency is `LATENCY`+1 cycles.
- `moc` is registered and deasserts one cycle after `mem_enable` falls.
- Earliest next request: sampled the cycle after returning to IDLE. Back-to-back spacing is `LATENCY`+3 cycles.
- Reset deassertion is recognised at the next rising edge; outputs stay at reset values until then.

## Configuration
- `RAM_ALIGN_CHECK_EN` defined:
  - A word access with `address[1:0]` ≠ 0 performs no access and goes to DONE after the normal latency.
  - `moc`=1 and `align_err`=1 in DONE; `data_out` is unchanged.
  - `align_err` clears with `moc`.
- `RAM_ALIGN_CHECK_EN` undefined:
  - Misaligned word accesses silently align down (bits [1:0] ignored).
  - `align_err` is tied 0.

## Test plan
- Reset mid-WAIT: request a write of `0xDEADBEEF` to address 0x10, pull `reset` low one cycle later -> `moc`=0, `data_out`=0, state IDLE; reading 0x10 afterwards returns its old value.
- Word write/read, `LATENCY`=2: write `0x11223344` to 0x20, then byte-read 0x20..0x23 -> `0x11`, `0x22`, `0x33`, `0x44` zero-extended. `moc` rises exactly 3 cycles after each request.
- Byte write: write byte `0xAB` to 0x21 over word `0x11223344`, word-read 0x20 -> `0x11AB3344`.
- Address wrap, `DEPTH`=512: word write `0xCAFEF00D` to 0x200 -> word read at 0x000 returns `0xCAFEF00D`.
- Handshake: hold `mem_enable` high 5 cycles after `moc` -> `moc` stays 1 for all 5 cycles, then drops one cycle after `mem_enable` falls. Abort during WAIT -> no `moc`, memory unchanged.
- Misaligned word read at 0x22:
  - With `RAM_ALIGN_CHECK_EN`: `moc`=1, `align_err`=1, `data_out` unchanged.
  - Without it: returns the word at 0x20, `align_err`=0.

Source files
------------

// File: rtl/ram_moc_unit.sv
// ram_moc_unit: byte-addressable big-endian memory with a multi-cycle
// Memory-Operation-Complete (moc) handshake for a multicycle CPU datapath.
// The byte-strobe port is named byte_en because `byte` is a reserved word.
// Optional feature: define RAM_ALIGN_CHECK_EN to flag misaligned word accesses
// on align_err instead of silently aligning them down.
module ram_moc_unit #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable,
  input  logic        rw,
  input  logic        byte_en,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        align_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          rw_q, byte_q;
  logic          capture, access, misalign, wr_en, rd_en;
  logic [AW-1:0] base;
  logic          moc_q;
  logic [31:0]   rdata_q;
  logic [7:0]    mem [DEPTH];

  // Address bits above the array size wrap away.
  logic unused_addr;
  assign unused_addr = ^address[31:AW];

  // Word accesses use the index with bits [1:0] cleared.
  assign base  = addr_q & ~AW'(3);
  assign wr_en = access & ~rw_q & ~misalign;
  assign rd_en = access & rw_q & ~misalign;

  // Next-state: capture in idle, count down latency, complete or abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_enable) begin
          capture = 1'b1;
          cnt_d   = 4'(LATENCY);
          state_d = StWait;
        end
      end
      StWait: begin
        if (!mem_enable) begin
          cnt_d   = 4'd0;
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (!mem_enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, request capture and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      byte_q  <= 1'b0;
      moc_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      moc_q   <= (state_d == StDone);
      if (capture) begin
        addr_q  <= address[AW-1:0];
        wdata_q <= data_in;
        rw_q    <= rw;
        byte_q  <= byte_en;
      end
      if (rd_en) begin
        if (byte_q) rdata_q <= {24'd0, mem[addr_q]};
        else        rdata_q <= {mem[base], mem[base | AW'(1)],
                                mem[base | AW'(2)], mem[base | AW'(3)]};
      end
    end
  end

  // Memory array has no reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (byte_q) begin
        mem[addr_q] <= wdata_q[7:0];
      end else begin
        mem[base]          <= wdata_q[31:24];
        mem[base | AW'(1)] <= wdata_q[23:16];
        mem[base | AW'(2)] <= wdata_q[15:8];
        mem[base | AW'(3)] <= wdata_q[7:0];
      end
    end
  end

`ifdef RAM_ALIGN_CHECK_EN
  logic align_q;

  assign misalign = ~byte_q & (addr_q[1:0] != 2'b00);

  // Flag set at access time, held through done, cleared together with moc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) align_q <= 1'b0;
    else if (access) align_q <= misalign;
    else if (state_d != StDone) align_q <= 1'b0;
  end

  assign align_err = align_q;
`else
  assign misalign  = 1'b0;
  assign align_err = 1'b0;
`endif

  assign data_out = rdata_q;
  assign moc      = moc_q;

endmodule

// File: tb/tb_ram_moc_unit.sv
// Self-checking bench for ram_moc_unit: directed requests, a reference byte
// model and a queue of expected read data popped when moc is seen.
module tb_ram_moc_unit;

  localparam int unsigned DEPTH   = 512;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_enable = 1'b0;
  logic        rw = 1'b0;
  logic        byte_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        moc;
  logic        align_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mdl [DEPTH];
  logic [31:0] sb [$];
  logic [31:0] tb_last = '0;

  ram_moc_unit #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_enable(mem_enable),
    .rw        (rw),
    .byte_en   (byte_en),
    .address   (address),
    .data_in   (data_in),
    .data_out  (data_out),
    .moc       (moc),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_mis(input logic b, input logic [31:0] a);
`ifdef RAM_ALIGN_CHECK_EN
    return !b && (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic b, input logic [31:0] a);
    int unsigned i;
    int unsigned w;
    i = a % DEPTH;
    w = i & ~32'd3;
    if (b) return {24'd0, mdl[i]};
    return {mdl[w], mdl[w+1], mdl[w+2], mdl[w+3]};
  endfunction

  function automatic void model_write(input logic b, input logic [31:0] a, input logic [31:0] d);
    int unsigned i;
    int unsigned w;
    i = a % DEPTH;
    w = i & ~32'd3;
    if (b) begin
      mdl[i] = d[7:0];
    end else begin
      mdl[w]   = d[31:24];
      mdl[w+1] = d[23:16];
      mdl[w+2] = d[15:8];
      mdl[w+3] = d[7:0];
    end
  endfunction

  // One full request: issue, scramble inputs after capture, wait for moc,
  // hold mem_enable 'hold' extra cycles, then release and check moc drops.
  task automatic req(input logic r, input logic b, input logic [31:0] a,
                     input logic [31:0] d, input int hold, input string tag);
    int cyc;
    logic m;
    logic [31:0] exp;
    m = is_mis(b, a);
    if (r) begin
      if (m) exp = tb_last;
      else begin
        exp = model_read(b, a);
        tb_last = exp;
      end
      sb.push_back(exp);
    end else if (!m) begin
      model_write(b, a, d);
    end
    mem_enable = 1'b1;
    rw = r;
    byte_en = b;
    address = a;
    data_in = d;
    @(posedge clk); #1;
    cyc = 1;
    address = $urandom;
    data_in = $urandom;
    byte_en = ~b;
    rw = ~r;
    while (!moc && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc - 1), 32'(LATENCY + 1));
    if (r) begin
      exp = sb.pop_front();
      chk({tag, " data"}, data_out, exp);
    end
    chk({tag, " align_err"}, {31'd0, align_err}, {31'd0, m});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " moc held"}, {31'd0, moc}, 32'd1);
    end
    mem_enable = 1'b0;
    @(posedge clk); #1;
    chk({tag, " moc drop"}, {31'd0, moc}, 32'd0);
    chk({tag, " align_err drop"}, {31'd0, align_err}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst moc", {31'd0, moc}, 32'd0);
    chk("rst data_out", data_out, 32'd0);
    chk("rst align_err", {31'd0, align_err}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("post-rst data_out", data_out, 32'd0);

    // Seed 0x10 and read it so data_out is non-zero before the reset test
    req(1'b0, 1'b0, 32'h10, 32'h01020304, 0, "seed wr 0x10");
    req(1'b1, 1'b0, 32'h10, 32'h0, 0, "seed rd 0x10");

    // Reset mid-WAIT on a write of DEADBEEF to 0x10
    mem_enable = 1'b1;
    rw = 1'b0;
    byte_en = 1'b0;
    address = 32'h10;
    data_in = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midwait rst moc", {31'd0, moc}, 32'd0);
    chk("midwait rst data_out", data_out, 32'd0);
    chk("midwait rst align_err", {31'd0, align_err}, 32'd0);
    tb_last = '0;
    mem_enable = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    req(1'b1, 1'b0, 32'h10, 32'h0, 0, "rd 0x10 after rst");

    // Word write, byte reads, big-endian
    req(1'b0, 1'b0, 32'h20, 32'h11223344, 0, "wr 0x20");
    req(1'b1, 1'b1, 32'h20, 32'h0, 0, "brd 0x20");
    req(1'b1, 1'b1, 32'h21, 32'h0, 0, "brd 0x21");
    req(1'b1, 1'b1, 32'h22, 32'h0, 0, "brd 0x22");
    req(1'b1, 1'b1, 32'h23, 32'h0, 0, "brd 0x23");

    // Byte write into a word
    req(1'b0, 1'b1, 32'h21, 32'hFFFFFFAB, 0, "bwr 0x21");
    req(1'b1, 1'b0, 32'h20, 32'h0, 0, "wrd 0x20");
    chk("byte merge", data_out, 32'h11AB3344);

    // Address wrap
    req(1'b0, 1'b0, 32'h200, 32'hCAFEF00D, 0, "wr 0x200");
    req(1'b1, 1'b0, 32'h000, 32'h0, 0, "rd 0x000");
    chk("wrap value", data_out, 32'hCAFEF00D);

    // Handshake: hold mem_enable 5 cycles after moc
    req(1'b1, 1'b0, 32'h20, 32'h0, 5, "hold rd 0x20");

    // Abort during WAIT leaves memory untouched
    req(1'b0, 1'b0, 32'h40, 32'h55667788, 0, "wr 0x40");
    mem_enable = 1'b1;
    rw = 1'b0;
    byte_en = 1'b0;
    address = 32'h40;
    data_in = 32'h99999999;
    @(posedge clk); #1;
    mem_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort moc", {31'd0, moc}, 32'd0);
    end
    req(1'b1, 1'b0, 32'h40, 32'h0, 0, "rd 0x40 after abort");

    // Misaligned word accesses
    req(1'b1, 1'b0, 32'h22, 32'h0, 0, "mis rd 0x22");
    req(1'b0, 1'b0, 32'h43, 32'hA5A5A5A5, 0, "mis wr 0x43");
    req(1'b1, 1'b0, 32'h40, 32'h0, 0, "rd 0x40 after mis wr");

    // A few random aligned word write/read pairs
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      a = 32'h100 + 32'(4 * $urandom_range(0, 63));
      req(1'b0, 1'b0, a, $urandom, 0, "rnd wr");
      req(1'b1, 1'b0, a, 32'h0, 0, "rnd rd");
    end

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
